// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation and FSM state encodings plus small op-decoding helpers.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    // Divide ops live in the upper half of the encoding space
    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    // MULT and DIV are the signed flavours
    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath on unsigned magnitudes.
// Multiply: LSB-first shift-add, {acc, reg} shifts right, reg holds multiplier.
// Divide:   restoring shift-subtract, acc holds partial remainder, reg holds
//           dividend bits shifting out and quotient bits shifting in.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] reg_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] reg_o
);

    logic [WIDTH:0]   addSum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    assign addSum  = acc_i + (reg_i[0] ? {1'b0, opnd_i} : {(WIDTH+1){1'b0}});
    assign shifted = {acc_i[WIDTH-1:0], reg_i[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, opnd_i};

    // Pick the shift-add or the restoring-subtract result for this iteration
    always_comb begin
        acc_o = acc_i;
        reg_o = reg_i;
        if (is_div) begin
            if (!diff[WIDTH+1]) begin
                acc_o = diff[WIDTH:0];
                reg_o = {reg_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = shifted;
                reg_o = {reg_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_o = {1'b0, addSum[WIDTH:1]};
            reg_o = {addSum[0], reg_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
// Works on operand magnitudes for WIDTH iterations, then fixes signs in a
// single final cycle and commits HI/LO with a one-cycle done pulse.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q;
    logic             isDiv_q;
    logic             sa_q;
    logic             sb_q;
    logic             divZero_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH-1:0] aRaw_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic             isDivIn;
    logic             isSignedIn;
    logic             saIn;
    logic             sbIn;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic [WIDTH:0]   stepAcc;
    logic [WIDTH-1:0] stepReg;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] productFix;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    assign isDivIn    = op_is_div(op_e'(op));
    assign isSignedIn = op_is_signed(op_e'(op));
    assign saIn       = isSignedIn & a[WIDTH-1];
    assign sbIn       = isSignedIn & b[WIDTH-1];
    assign absA       = saIn ? (~a + 1'b1) : a;
    assign absB       = sbIn ? (~b + 1'b1) : b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (isDiv_q),
        .acc_i  (acc_q),
        .reg_i  (reg_q),
        .opnd_i (opnd_q),
        .acc_o  (stepAcc),
        .reg_o  (stepReg)
    );

    assign product    = {acc_q[WIDTH-1:0], reg_q};
    assign productFix = (sa_q ^ sb_q) ? (~product + 1'b1) : product;

    // Sign-corrected result; divide-by-zero overrides whatever the loop produced
    always_comb begin
        hi_d = productFix[2*WIDTH-1:WIDTH];
        lo_d = productFix[WIDTH-1:0];
        if (isDiv_q) begin
            if (divZero_q) begin
                hi_d = aRaw_q;
                lo_d = {WIDTH{1'b1}};
            end else begin
                lo_d = (sa_q ^ sb_q) ? (~reg_q + 1'b1) : reg_q;
                hi_d = sa_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
            end
        end
    end

    // Control FSM, iteration registers and architectural HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            isDiv_q   <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            divZero_q <= 1'b0;
            count_q   <= '0;
            acc_q     <= '0;
            reg_q     <= '0;
            opnd_q    <= '0;
            aRaw_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hi_we) hi_q <= wd;
                    if (lo_we) lo_q <= wd;
                    if (start) begin
                        isDiv_q   <= isDivIn;
                        sa_q      <= saIn;
                        sb_q      <= sbIn;
                        divZero_q <= isDivIn && (b == '0);
                        aRaw_q    <= a;
                        acc_q     <= '0;
                        reg_q     <= isDivIn ? absA : absB;
                        opnd_q    <= isDivIn ? absB : absA;
                        count_q   <= CW'(WIDTH - 1);
                        busy_q    <= 1'b1;
                        state_q   <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc_q <= stepAcc;
                    reg_q <= stepReg;
                    if (count_q == '0) begin
                        state_q <= S_FIX;
                    end else begin
                        count_q <= count_q - 1'b1;
                    end
                end
                S_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
